// File: rtl/jt12_kon_defs.sv
// Shared constants and types for the key-on scheduler.
// Register 0x28 field layout and FIFO entry format.
package jt12_kon_defs;

  localparam int SLOTS_DEF = 24;
  localparam int DEPTH_DEF = 4;

  localparam int MASK_HI = 7;
  localparam int MASK_LO = 4;
  localparam int CH_HI   = 2;
  localparam int CH_LO   = 0;

  localparam logic [1:0] CH_BAD = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_APPLY
  } st_e;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] ch;
  } kon_t;

  function automatic logic ch_bad(
    input logic [2:0] ch
  );
    return ch[1:0] == CH_BAD;
  endfunction

endpackage

// File: rtl/jt12_kon_fifo.sv
// Small synchronous FIFO holding pending key-on writes.
// Pointers carry a wrap bit to tell full from empty.
module jt12_kon_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign empty  = r_wptr == r_rptr;
  assign full   = (r_wptr[AW] != r_rptr[AW]) &&
                  (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rptr[AW-1:0]];

  // Pointer update; storage itself needs no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jt12_kon_sched.sv
// Key-on write scheduler: queues 0x28 writes and holds
// up_keyon for one full slot revolution per write.
module jt12_kon_sched
  import jt12_kon_defs::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [3:0] keyon_op,
  output logic [2:0] keyon_ch,
  output logic       up_keyon,
  output logic       busy,
  output logic       ovf,
  output logic       bad_ch,
  input  logic       flag_clr
);

  localparam int CW = $clog2(SLOTS);

  st_e         r_state;
  st_e         w_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_op;
  logic [2:0]  r_ch;
  logic        r_ovf;
  logic        r_bad;

  kon_t        w_in;
  kon_t        w_head;
  logic [6:0]  w_dout;
  logic        w_full;
  logic        w_empty;
  logic        w_wr_bad;
  logic        w_push;
  logic        w_pop;
  logic        w_end;
  logic        w_ovf_set;
  logic        w_unused;

  assign w_unused  = wr_data[3];
  assign w_in.op   = wr_data[MASK_HI:MASK_LO];
  assign w_in.ch   = wr_data[CH_HI:CH_LO];
  assign w_wr_bad  = wr_valid && ch_bad(w_in.ch);
  assign w_push    = wr_valid && !w_wr_bad && !w_full;
  assign w_ovf_set = wr_valid && !w_wr_bad && w_full;
  assign w_head    = kon_t'(w_dout);

  jt12_kon_fifo #(
    .DEPTH (DEPTH),
    .W     (7)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_in),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // State, window counter and applied-write registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_ch    <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_pop) begin
        r_op  <= w_head.op;
        r_ch  <= w_head.ch;
        r_cnt <= '0;
      end else if (w_end) begin
        r_cnt <= '0;
      end else if (r_state == ST_APPLY) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Next state: leave APPLY only when a window ends dry
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (!w_empty) w_nxt = ST_APPLY;
      ST_APPLY: if (w_end && w_empty) w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  // Outputs: pop at window start or back-to-back reload
  always_comb begin
    w_end    = (r_state == ST_APPLY) &&
               (r_cnt == CW'(SLOTS - 1));
    w_pop    = !w_empty &&
               ((r_state == ST_IDLE) || w_end);
    up_keyon = r_state == ST_APPLY;
    busy     = up_keyon || !w_empty;
    wr_ready = !w_full;
    keyon_op = r_op;
    keyon_ch = r_ch;
    ovf      = r_ovf;
    bad_ch   = r_bad;
  end

  // Sticky error flags; a new event beats flag_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_bad <= 1'b0;
    end else begin
      if (w_ovf_set)     r_ovf <= 1'b1;
      else if (flag_clr) r_ovf <= 1'b0;
      if (w_wr_bad)      r_bad <= 1'b1;
      else if (flag_clr) r_bad <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt12_kon_sched.sv
// Directed self-checking bench for jt12_kon_sched.
// Each task drives one scenario and checks inline.
module tb_jt12_kon_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon;
  logic       busy;
  logic       ovf;
  logic       bad_ch;
  logic       flag_clr;

  int errors = 0;
  int checks = 0;

  jt12_kon_sched #(
    .SLOTS (24),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .keyon_op (keyon_op),
    .keyon_ch (keyon_ch),
    .up_keyon (up_keyon),
    .busy     (busy),
    .ovf      (ovf),
    .bad_ch   (bad_ch),
    .flag_clr (flag_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    flag_clr = 1'b0;
    tick();
    tick();
    checks++;
    if (up_keyon !== 1'b0) begin
      errors++;
      $display("FAIL reset_up got=%b exp=0", up_keyon);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", wr_ready);
    end
    checks++;
    if (keyon_op !== 4'h0 || keyon_ch !== 3'd0) begin
      errors++;
      $display("FAIL reset_opch got=%h/%0d exp=0/0",
               keyon_op, keyon_ch);
    end
    checks++;
    if (ovf !== 1'b0 || bad_ch !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b%b exp=00", ovf, bad_ch);
    end
    rst = 1'b0;
    tick();
  endtask

  // Write at edge 10: window covers cycles 11..34
  task automatic test_single;
    logic exp_up;
    for (int t = 0; t <= 40; t++) begin
      wr_valid = (t == 10);
      wr_data = 8'hF1;
      tick();
      exp_up = (t >= 11) && (t <= 34);
      checks++;
      if (up_keyon !== exp_up) begin
        errors++;
        $display("FAIL single_up t=%0d got=%b exp=%b",
                 t, up_keyon, exp_up);
      end
      if (t >= 11) begin
        checks++;
        if (keyon_op !== 4'hF || keyon_ch !== 3'd1) begin
          errors++;
          $display("FAIL single_opch t=%0d got=%h/%0d exp=f/1",
                   t, keyon_op, keyon_ch);
        end
      end
      if (t == 10) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_q got=%b exp=1", busy);
        end
      end
      if (t == 35) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL single_busy_end got=%b exp=0", busy);
        end
      end
    end
    wr_valid = 1'b0;
  endtask

  // Three queued writes form one 72-cycle window run
  task automatic test_back_to_back;
    logic [7:0] bb [3];
    logic       exp_up;
    int         k;
    bb = '{8'h10, 8'h25, 8'h46};
    for (int t = 0; t <= 80; t++) begin
      wr_valid = (t < 3);
      wr_data = (t < 3) ? bb[t] : 8'h00;
      tick();
      exp_up = (t >= 1) && (t <= 72);
      checks++;
      if (up_keyon !== exp_up) begin
        errors++;
        $display("FAIL b2b_up t=%0d got=%b exp=%b",
                 t, up_keyon, exp_up);
      end
      if (t >= 1) begin
        k = (t - 1) / 24;
        if (k > 2) k = 2;
        checks++;
        if (keyon_op !== bb[k][7:4] ||
            keyon_ch !== bb[k][2:0]) begin
          errors++;
          $display("FAIL b2b_opch t=%0d got=%h/%0d exp=%h/%0d",
                   t, keyon_op, keyon_ch,
                   bb[k][7:4], bb[k][2:0]);
        end
      end
      if (t == 73) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_busy got=%b exp=0", busy);
        end
      end
    end
    wr_valid = 1'b0;
  endtask

  // Invalid channel codes are consumed and flagged
  task automatic test_bad_ch;
    for (int t = 0; t <= 5; t++) begin
      wr_valid = (t < 2);
      wr_data = (t == 0) ? 8'hF3 : 8'hF7;
      tick();
      checks++;
      if (up_keyon !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_idle t=%0d got=%b%b exp=00",
                 t, up_keyon, busy);
      end
      checks++;
      if (bad_ch !== 1'b1 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL bad_flag t=%0d got=%b/%b exp=1/0",
                 t, bad_ch, ovf);
      end
    end
    wr_valid = 1'b0;
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (bad_ch !== 1'b0) begin
      errors++;
      $display("FAIL bad_clr got=%b exp=0", bad_ch);
    end
    flag_clr = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h13;
    tick();
    flag_clr = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (bad_ch !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_wins got=%b/%b exp=1/0", bad_ch, busy);
    end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
  endtask

  // Six writes into a 4-deep FIFO: sixth is dropped
  task automatic test_overflow;
    logic [7:0] ov [6];
    logic       exp_up;
    int         k;
    ov = '{8'h10, 8'h21, 8'h42, 8'h84, 8'h15, 8'h26};
    for (int t = 0; t <= 130; t++) begin
      wr_valid = (t < 6);
      wr_data = (t < 6) ? ov[t] : 8'h00;
      tick();
      exp_up = (t >= 1) && (t <= 120);
      checks++;
      if (up_keyon !== exp_up) begin
        errors++;
        $display("FAIL ovf_up t=%0d got=%b exp=%b",
                 t, up_keyon, exp_up);
      end
      if (t >= 1) begin
        k = (t - 1) / 24;
        if (k > 4) k = 4;
        checks++;
        if (keyon_op !== ov[k][7:4] ||
            keyon_ch !== ov[k][2:0]) begin
          errors++;
          $display("FAIL ovf_opch t=%0d got=%h/%0d exp=%h/%0d",
                   t, keyon_op, keyon_ch,
                   ov[k][7:4], ov[k][2:0]);
        end
      end
      if (t == 3 || t == 4 || t == 5 || t == 25) begin
        checks++;
        if (wr_ready !== (t == 3 || t == 25)) begin
          errors++;
          $display("FAIL ovf_ready t=%0d got=%b", t, wr_ready);
        end
        checks++;
        if (ovf !== (t >= 5)) begin
          errors++;
          $display("FAIL ovf_flag t=%0d got=%b", t, ovf);
        end
      end
      if (t == 121) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL ovf_busy got=%b exp=0", busy);
        end
      end
    end
    wr_valid = 1'b0;
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got=%b exp=0", ovf);
    end
  endtask

  // Full FIFO, push rejected on the same edge as a pop
  task automatic test_full_push_pop;
    logic [7:0] fp [5];
    logic       exp_up;
    int         k;
    fp = '{8'h11, 8'h22, 8'h44, 8'h81, 8'h12};
    for (int t = 0; t <= 130; t++) begin
      wr_valid = (t < 5) || (t == 25);
      wr_data = (t < 5) ? fp[t] : 8'h86;
      tick();
      exp_up = (t >= 1) && (t <= 120);
      checks++;
      if (up_keyon !== exp_up) begin
        errors++;
        $display("FAIL fpp_up t=%0d got=%b exp=%b",
                 t, up_keyon, exp_up);
      end
      if (t >= 1) begin
        k = (t - 1) / 24;
        if (k > 4) k = 4;
        checks++;
        if (keyon_op !== fp[k][7:4] ||
            keyon_ch !== fp[k][2:0]) begin
          errors++;
          $display("FAIL fpp_opch t=%0d got=%h/%0d exp=%h/%0d",
                   t, keyon_op, keyon_ch,
                   fp[k][7:4], fp[k][2:0]);
        end
      end
      if (t == 24 || t == 25) begin
        checks++;
        if (wr_ready !== (t == 25) || ovf !== (t == 25)) begin
          errors++;
          $display("FAIL fpp_edge t=%0d got=%b/%b exp=%b/%b",
                   t, wr_ready, ovf, t == 25, t == 25);
        end
      end
      if (t == 125) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL fpp_busy got=%b exp=0", busy);
        end
      end
    end
    wr_valid = 1'b0;
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
  endtask

  // Reset in the middle of a window with two writes queued
  task automatic test_reset_mid;
    logic [7:0] rm [3];
    rm = '{8'h11, 8'h22, 8'h44};
    for (int t = 0; t <= 12; t++) begin
      wr_valid = (t < 3);
      wr_data = (t < 3) ? rm[t] : 8'h00;
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (up_keyon !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got=%b%b exp=11", up_keyon, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (up_keyon !== 1'b0 || busy !== 1'b0 ||
        wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ctl got=%b%b%b exp=001",
               up_keyon, busy, wr_ready);
    end
    checks++;
    if (keyon_op !== 4'h0 || keyon_ch !== 3'd0) begin
      errors++;
      $display("FAIL rmid_opch got=%h/%0d exp=0/0",
               keyon_op, keyon_ch);
    end
    for (int t = 0; t < 60; t++) begin
      tick();
      checks++;
      if (up_keyon !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rmid_after t=%0d got=%b%b exp=00",
                 t, up_keyon, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_ch();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt12_kon_sched.md
Name: jt12_kon_sched

Overview:
Schedules key-on register (0x28) writes into the per-slot key-on shift-register datapath. It buffers CPU key-on writes in a small FIFO and presents one write at a time as keyon_op/keyon_ch. It holds up_keyon for exactly one full slot revolution (SLOTS cycles), so every operator slot of the target channel samples the new key state exactly once. It sits between the register interface and the key-on shift stage, driving that stage's keyon_op, keyon_ch and up_keyon inputs.

Parameters:
SLOTS, 24, slots per revolution; length of the up_keyon window in clk cycles
DEPTH, 4, FIFO entries (power of two, 2..16)

Ports:
clk  in  1  system clock, every cycle is one slot
rst  in  1  synchronous active-high reset
wr_valid  in  1  key-on write strobe
wr_data  in  8  raw reg 0x28 value: [7:4] op mask S4,S3,S2,S1; [2:0] channel code
wr_ready  out  1  FIFO can accept a write this cycle
keyon_op  out  4  op mask of the write being applied
keyon_ch  out  3  channel code of the write being applied
up_keyon  out  1  high while the applied write is valid for the shift stage
busy  out  1  window active or FIFO non-empty
ovf  out  1  sticky: write arrived while FIFO full (dropped)
bad_ch  out  1  sticky: write with invalid channel code discarded
flag_clr  in  1  clears ovf and bad_ch

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: FIFO empty, up_keyon=0, keyon_op=0, keyon_ch=0, ovf=0, bad_ch=0, busy=0, wr_ready=1, window counter=0.
- Channel codes:
  - 0,1,2,4,5,6 are valid and are passed through unchanged (same encoding as the slot sequencer's cur_ch).
  - Codes with [1:0]==2'b11 (3 and 7) are invalid. An invalid write is consumed and not queued, and bad_ch is set.
- Write accept:
  - wr_ready = !full.
  - wr_valid && wr_ready with a valid code pushes {mask, ch}.
  - wr_valid && !wr_ready: the write is dropped and ovf is set. A pop in the same cycle does not rescue it (no bypass).
- States: IDLE and APPLY; the window counter is $clog2(SLOTS) bits.
- IDLE: when the FIFO is non-empty at an edge, pop, register keyon_op/keyon_ch, set up_keyon=1, counter=0, and go to APPLY.
- APPLY: counter increments each cycle.
  - On the edge where counter==SLOTS-1 with the FIFO non-empty: pop the next entry, load it, counter=0, up_keyon stays 1 (back-to-back windows, no gap).
  - On that edge with the FIFO empty: up_keyon=0, go to IDLE. keyon_op/keyon_ch hold their last value.
- Latency: a write accepted at edge N is visible on the outputs after edge N+1 (up_keyon=1). up_keyon falls after edge N+1+SLOTS if nothing else is queued.
- Window coverage: each window is exactly SLOTS consecutive cycles, so it covers every slot once regardless of starting phase. No alignment to slot 0 is required.
- Empty FIFO with a push at edge N: the entry becomes poppable at edge N+1 (no same-cycle bypass).
- Ordering: writes are applied strictly in FIFO order. Repeated writes to the same channel are not merged.
- flag_clr and a new error event in the same cycle: the event wins and the flag stays set.
- Reset mid-window: up_keyon drops on the reset edge and queued writes are lost. Operators keep whatever the shift stage already latched.
- busy = up_keyon || !empty.

Decomposition:
- Shared package/header jt12_kon_defs: SLOTS default, invalid channel test pattern, 0x28 field positions.
- One sub-module, jt12_kon_fifo:
  - Synchronous FIFO with DEPTH entries of 7-bit data.
  - Ports: push, pop, din, dout, full, empty; read and write pointers with a wrap bit.
- Control FSM and counter live in jt12_kon_sched.

Test Plan:
- Single write 0xF1 at cycle 10 -> keyon_op=4'hF, keyon_ch=1, up_keyon high cycles 11..34, low at 35, busy low at 35.
- Writes 0x10, 0x25, 0x46 at cycles 0,1,2 -> three contiguous 24-cycle windows (ch 0, 5, 6; masks 1, 2, 4), up_keyon continuously high for 72 cycles.
- Write 0xF3 then 0xF7 -> nothing queued, up_keyon stays 0, bad_ch=1. flag_clr -> bad_ch=0.
- With DEPTH=4, 6 writes in 6 consecutive cycles while idle -> first popped at cycle 1, 4 queued, wr_ready low, 6th write dropped, ovf=1. The remaining 5 windows apply in order.
- Assert rst at cycle 12 of a window with 2 writes queued -> next cycle up_keyon=0, busy=0, wr_ready=1, keyon_op=0, keyon_ch=0, and no further windows.
- FIFO full, push and pop on the same edge -> push rejected (ovf=1), count drops by one, and wr_ready is high the following cycle.
